// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: steps an NCO through a frequency sweep for the IQ demodulator.
//
// For each frequency point the controller does four things:
//   1. Retunes the NCO phase increment.
//   2. Waits a programmable settle interval.
//   3. Passes exactly cfg_dwell valid NCO samples through as measurement samples,
//      each tagged with the index of the current point.
//   4. Steps the increment, or finishes the sweep.
//
// Ports
//   clk, reset_n        clock; synchronous active-low reset
//   cfg_valid/ready     configuration handshake into shadow registers
//   cfg_start_inc       first phase increment of the sweep
//   cfg_stop_inc        last allowed increment (unsigned, inclusive)
//   cfg_step_inc        increment added between points
//   cfg_dwell           measurement samples per point (0 behaves as 1)
//   cfg_settle          settle length; the SETTLE state lasts cfg_settle+1 cycles
//   start, abort, hold  sweep control inputs
//   nco_out_valid       sample strobe from the NCO
//   nco_phi_inc         registered phase increment to the NCO
//   nco_clken           NCO clock enable (low while hold is high)
//   busy                sweep in progress (state != IDLE)
//   meas_valid          current NCO sample belongs to the dwell window
//   meas_last           final sample of the dwell window
//   step_idx            registered index of the current frequency point
//   sweep_done          one-cycle pulse on normal completion
//   aborted             one-cycle pulse when an abort is taken
//   dbg_state           current FSM state, for observation only
//
// Handshake: a configuration word transfers on a rising clk edge where both
// cfg_valid and cfg_ready are high. cfg_ready depends only on the state, never
// on cfg_valid. cfg_valid may be raised or dropped at any time.
module nco_sweep_ctrl #(
    parameter int PHI_W    = 32,
    parameter int DWELL_W  = 16,
    parameter int SETTLE_W = 8,
    parameter int IDX_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [PHI_W-1:0]    cfg_start_inc,
    input  logic [PHI_W-1:0]    cfg_stop_inc,
    input  logic [PHI_W-1:0]    cfg_step_inc,
    input  logic [DWELL_W-1:0]  cfg_dwell,
    input  logic [SETTLE_W-1:0] cfg_settle,
    input  logic                start,
    input  logic                abort,
    input  logic                hold,
    input  logic                nco_out_valid,
    output logic [PHI_W-1:0]    nco_phi_inc,
    output logic                nco_clken,
    output logic                busy,
    output logic                meas_valid,
    output logic                meas_last,
    output logic [IDX_W-1:0]    step_idx,
    output logic                sweep_done,
    output logic                aborted,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_DWELL  = 3'd2,
        S_STEP   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Shadow configuration used by the running sweep.
    logic [PHI_W-1:0]    start_inc_q, stop_inc_q, step_inc_q;
    logic [DWELL_W-1:0]  dwell_q;
    logic [SETTLE_W-1:0] settle_q;

    logic [PHI_W-1:0]    phi_q, phi_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic                sweep_done_q, sweep_done_d;
    logic                aborted_q, aborted_d;

    logic                cfg_fire;
    logic [DWELL_W-1:0]  dwell_eff;
    logic [PHI_W:0]      next_inc;
    logic                sweep_end;

    assign cfg_ready  = (state_q == S_IDLE);
    assign cfg_fire   = cfg_valid & cfg_ready;
    assign busy       = (state_q != S_IDLE);
    assign nco_clken  = ~hold;
    assign dwell_eff  = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
    assign meas_valid = (state_q == S_DWELL) & nco_out_valid & ~hold;
    assign meas_last  = meas_valid & (dwell_cnt_q == dwell_eff - DWELL_W'(1));

    // One extra bit so that wrap-around past all-ones ends the sweep instead
    // of restarting from a small increment.
    assign next_inc  = {1'b0, phi_q} + {1'b0, step_inc_q};
    assign sweep_end = (step_inc_q == '0) | next_inc[PHI_W] |
                       (next_inc[PHI_W-1:0] > stop_inc_q);

    assign nco_phi_inc = phi_q;
    assign step_idx    = idx_q;
    assign sweep_done  = sweep_done_q;
    assign aborted     = aborted_q;
    assign dbg_state   = state_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        phi_d        = phi_q;
        idx_d        = idx_q;
        settle_cnt_d = settle_cnt_q;
        dwell_cnt_d  = dwell_cnt_q;
        sweep_done_d = 1'b0;
        aborted_d    = 1'b0;

        if (abort && (state_q != S_IDLE)) begin
            // Abort wins over hold and over a same-cycle meas_last.
            state_d   = S_IDLE;
            aborted_d = 1'b1;
        end else if ((state_q == S_IDLE) || !hold) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        // A config word accepted in this same cycle applies to
                        // this sweep, so bypass the shadow registers.
                        phi_d        = cfg_fire ? cfg_start_inc : start_inc_q;
                        settle_cnt_d = cfg_fire ? cfg_settle : settle_q;
                        idx_d        = '0;
                        dwell_cnt_d  = '0;
                        state_d      = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_q == '0) begin
                        state_d = S_DWELL;
                    end else begin
                        settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
                    end
                end
                S_DWELL: begin
                    if (meas_valid) begin
                        dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                        if (meas_last) begin
                            state_d = S_STEP;
                        end
                    end
                end
                S_STEP: begin
                    if (sweep_end) begin
                        state_d      = S_DONE;
                        sweep_done_d = 1'b1;
                    end else begin
                        phi_d        = next_inc[PHI_W-1:0];
                        idx_d        = (&idx_q) ? idx_q : idx_q + IDX_W'(1);
                        settle_cnt_d = settle_q;
                        dwell_cnt_d  = '0;
                        state_d      = S_SETTLE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phi_q        <= '0;
            idx_q        <= '0;
            settle_cnt_q <= '0;
            dwell_cnt_q  <= '0;
            sweep_done_q <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            phi_q        <= phi_d;
            idx_q        <= idx_d;
            settle_cnt_q <= settle_cnt_d;
            dwell_cnt_q  <= dwell_cnt_d;
            sweep_done_q <= sweep_done_d;
            aborted_q    <= aborted_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            start_inc_q <= '0;
            stop_inc_q  <= '0;
            step_inc_q  <= '0;
            dwell_q     <= '0;
            settle_q    <= '0;
        end else if (cfg_fire) begin
            start_inc_q <= cfg_start_inc;
            stop_inc_q  <= cfg_stop_inc;
            step_inc_q  <= cfg_step_inc;
            dwell_q     <= cfg_dwell;
            settle_q    <= cfg_settle;
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Testbench for nco_sweep_ctrl.
//
// Test tasks drive the inputs. When a sweep is issued, the reference model
// computes the frequency points with plain 64-bit arithmetic and pushes one
// expected {last, idx, phi} entry per measurement sample. A monitor running on
// the falling clock edge pops and compares an entry whenever meas_valid is high.
module tb_nco_sweep_ctrl;
    localparam int PHI_W    = 32;
    localparam int DWELL_W  = 16;
    localparam int SETTLE_W = 8;
    localparam int IDX_W    = 16;
    localparam int EXP_W    = 1 + IDX_W + PHI_W;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [PHI_W-1:0]    cfg_start_inc, cfg_stop_inc, cfg_step_inc;
    logic [DWELL_W-1:0]  cfg_dwell;
    logic [SETTLE_W-1:0] cfg_settle;
    logic                start, abort, hold;
    logic                hold_dir, hold_rnd, rnd_hold_en;
    logic                nco_out_valid;
    logic [PHI_W-1:0]    nco_phi_inc;
    logic                nco_clken, busy, meas_valid, meas_last;
    logic [IDX_W-1:0]    step_idx;
    logic                sweep_done, aborted;
    logic [2:0]          dbg_state;

    assign hold = hold_dir | hold_rnd;

    nco_sweep_ctrl #(
        .PHI_W(PHI_W), .DWELL_W(DWELL_W), .SETTLE_W(SETTLE_W), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_start_inc(cfg_start_inc), .cfg_stop_inc(cfg_stop_inc),
        .cfg_step_inc(cfg_step_inc), .cfg_dwell(cfg_dwell), .cfg_settle(cfg_settle),
        .start(start), .abort(abort), .hold(hold), .nco_out_valid(nco_out_valid),
        .nco_phi_inc(nco_phi_inc), .nco_clken(nco_clken), .busy(busy),
        .meas_valid(meas_valid), .meas_last(meas_last), .step_idx(step_idx),
        .sweep_done(sweep_done), .aborted(aborted), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EXP_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int done_seen = 0, aborted_seen = 0, exp_done = 0, exp_aborted = 0;
    logic [PHI_W-1:0] exp_last_phi;
    logic [IDX_W-1:0] exp_last_idx;
    int valid_mode = 0;  // 0: always valid, 1: alternating, 2: random

    // Reference model configuration (mirrors what the DUT should have captured).
    logic [31:0] m_start, m_stop, m_step;
    logic [15:0] m_dwell;
    logic [7:0]  m_settle;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
        end
    endtask

    // Walk the sweep points with wide arithmetic; max_pts > 0 truncates (abort).
    task automatic push_expected(input int max_pts);
        longint unsigned p, n;
        int np, dw;
        logic [IDX_W-1:0] idx_v;
        logic [PHI_W-1:0] phi_v;
        p  = 64'(m_start);
        np = 0;
        dw = (m_dwell == 16'd0) ? 1 : int'(m_dwell);
        forever begin
            idx_v = np[IDX_W-1:0];
            phi_v = p[PHI_W-1:0];
            for (int s = 0; s < dw; s++)
                exp_q.push_back({(s == dw - 1), idx_v, phi_v});
            exp_last_phi = phi_v;
            exp_last_idx = idx_v;
            np++;
            if (max_pts > 0 && np >= max_pts) break;
            if (m_step == 32'd0) break;
            n = p + 64'(m_step);
            if (n > 64'hFFFF_FFFF || n > 64'(m_stop)) break;
            p = n;
        end
    endtask

    // ---------------- stimulus background: NCO valid and random hold ----------------
    initial begin
        nco_out_valid = 1'b1;
        hold_rnd      = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (valid_mode)
                0:       nco_out_valid = 1'b1;
                1:       nco_out_valid = ~nco_out_valid;
                default: nco_out_valid = ($urandom_range(0, 1) == 1);
            endcase
            hold_rnd = rnd_hold_en && ($urandom_range(0, 7) == 0);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        check("nco_clken", nco_clken, !hold);
        if (meas_valid) begin
            if (hold) begin
                checks++; errors++;
                $display("FAIL meas_in_hold actual meas_valid=1 expected 0");
            end
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL meas_unexpected actual sample phi=%0h idx=%0d expected none", nco_phi_inc, step_idx);
            end else begin
                e = exp_q.pop_front();
                check("meas_last", meas_last, e[EXP_W-1]);
                check("meas_idx", step_idx, e[PHI_W +: IDX_W]);
                check("meas_phi", nco_phi_inc, e[PHI_W-1:0]);
            end
        end else if (meas_last === 1'b1) begin
            checks++; errors++;
            $display("FAIL meas_last_alone actual meas_last=1 expected 0");
        end
        if (sweep_done === 1'b1) begin
            done_seen++;
            check("done_phi", nco_phi_inc, exp_last_phi);
            check("done_idx", step_idx, exp_last_idx);
        end
        if (aborted === 1'b1) aborted_seen++;
    end

    // ---------------- driver tasks ----------------
    task automatic set_model(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                             input logic [15:0] d, input logic [7:0] se);
        m_start = s; m_stop = e; m_step = st; m_dwell = d; m_settle = se;
        cfg_start_inc = s; cfg_stop_inc = e; cfg_step_inc = st; cfg_dwell = d; cfg_settle = se;
    endtask

    task automatic load_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                            input logic [15:0] d, input logic [7:0] se);
        @(posedge clk); #1;
        set_model(s, e, st, d, se);
        cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic start_with_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                                  input logic [15:0] d, input logic [7:0] se);
        @(posedge clk); #1;
        set_model(s, e, st, d, se);
        push_expected(0);
        exp_done++;
        cfg_valid = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual busy=1 after %0d cycles expected busy=0", name, budget);
        end
    endtask

    task automatic end_checks(input string name);
        check({name, "_queue_left"}, exp_q.size(), 0);
        check({name, "_done_count"}, done_seen, exp_done);
        check({name, "_abort_count"}, aborted_seen, exp_aborted);
        exp_q.delete();
    endtask

    task automatic run_sweep(input string name);
        push_expected(0);
        exp_done++;
        pulse_start();
        wait_idle(2000, name);
        end_checks(name);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [PHI_W-1:0] phi_h;
        logic [IDX_W-1:0] idx_h;
        bit found;
        int lat;
        reset_n = 1'b0; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
        hold_dir = 1'b0; rnd_hold_en = 1'b0;
        set_model(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_phi", nco_phi_inc, 0);
        check("rst_idx", step_idx, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", sweep_done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_meas_valid", meas_valid, 0);
        reset_n = 1'b1;

        // Zeroed shadow config: one point at 0, dwell 0 behaves as 1.
        run_sweep("zero_cfg");

        // Basic sweep with settle latency measurement.
        load_cfg(100, 400, 100, 4, 2);
        push_expected(0);
        exp_done++;
        pulse_start();
        check("basic_first_phi", nco_phi_inc, 100);
        lat = 0;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk); #1;
            lat++;
            if (meas_valid) found = 1;
        end
        check("basic_settle_latency", lat, 3);
        wait_idle(2000, "basic");
        end_checks("basic");

        // Degenerate single-point sweeps.
        load_cfg(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 2, 1);
        run_sweep("carry");
        load_cfg(1234, 9999, 0, 3, 0);
        run_sweep("step_zero");
        load_cfg(500, 100, 50, 2, 1);
        run_sweep("start_gt_stop");

        // Sparse valid samples.
        valid_mode = 1;
        load_cfg(1000, 3000, 1000, 3, 0);
        run_sweep("sparse");
        valid_mode = 0;

        // Hold for 5 cycles in the middle of point 1's dwell.
        load_cfg(100, 300, 100, 6, 1);
        push_expected(0);
        exp_done++;
        pulse_start();
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #2;
            if (meas_valid && step_idx == 1) found = 1;
        end
        check("hold_reached", found, 1);
        hold_dir = 1'b1;
        phi_h = nco_phi_inc;
        idx_h = step_idx;
        repeat (5) @(posedge clk);
        #2;
        check("hold_clken", nco_clken, 0);
        check("hold_meas_valid", meas_valid, 0);
        check("hold_busy", busy, 1);
        check("hold_phi", nco_phi_inc, phi_h);
        check("hold_idx", step_idx, idx_h);
        hold_dir = 1'b0;
        #1;
        check("hold_resume", meas_valid, 1);
        wait_idle(2000, "hold");
        end_checks("hold");

        // Abort on the meas_last cycle of point 2.
        load_cfg(100, 400, 100, 4, 2);
        push_expected(3);
        exp_aborted++;
        pulse_start();
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk); #2;
            if (meas_last && step_idx == 2) found = 1;
        end
        check("abort_reached", found, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_pulse", aborted, 1);
        check("abort_busy", busy, 0);
        check("abort_idx", step_idx, 2);
        check("abort_phi", nco_phi_inc, 300);
        check("abort_no_done", sweep_done, 0);
        @(posedge clk); #1;
        check("abort_pulse_end", aborted, 0);
        end_checks("abort");

        // Restart after abort; an offered config while busy must be refused.
        push_expected(0);
        exp_done++;
        pulse_start();
        check("restart_phi", nco_phi_inc, 100);
        check("restart_idx", step_idx, 0);
        @(posedge clk); #1;
        cfg_start_inc = 32'h5555; cfg_stop_inc = 32'h9999; cfg_step_inc = 32'h11;
        cfg_dwell = 16'd9; cfg_settle = 8'd7;
        cfg_valid = 1'b1;
        #1;
        check("busy_cfg_ready", cfg_ready, 0);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        wait_idle(2000, "restart");
        end_checks("restart");
        run_sweep("cfg_not_captured");

        // Config and start in the same cycle.
        start_with_cfg(2000, 2600, 300, 2, 1);
        check("same_cycle_phi", nco_phi_inc, 2000);
        wait_idle(2000, "same_cycle");
        end_checks("same_cycle");

        // Reset in the middle of SETTLE.
        load_cfg(5000, 6000, 500, 2, 10);
        pulse_start();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_phi", nco_phi_inc, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cfg_ready", cfg_ready, 1);
        check("midrst_idx", step_idx, 0);
        reset_n = 1'b1;
        set_model(0, 0, 0, 0, 0);
        run_sweep("after_reset");

        // Randomized sweeps with random valid and random hold.
        valid_mode  = 2;
        rnd_hold_en = 1'b1;
        for (int it = 0; it < 12; it++) begin
            longint unsigned s, st, e;
            s  = 64'($urandom);
            st = 64'($urandom_range(1, 1000));
            if ($urandom_range(0, 4) == 0) begin
                s = 64'(32'hFFFF_F000 | 32'($urandom_range(0, 4095)));
                e = 64'h FFFF_FFFF;
            end else begin
                e = s + st * 64'($urandom_range(0, 5)) + 64'($urandom_range(0, 999)) % st;
                if (e > 64'hFFFF_FFFF) e = 64'hFFFF_FFFF;
            end
            if ($urandom_range(0, 5) == 0 && s > 0) e = s - 1;
            if ($urandom_range(0, 5) == 0) st = 0;
            if ($urandom_range(0, 1) == 0) begin
                start_with_cfg(s[31:0], e[31:0], st[31:0],
                               16'($urandom_range(0, 5)), 8'($urandom_range(0, 4)));
                wait_idle(2000, "rand");
                end_checks("rand");
            end else begin
                load_cfg(s[31:0], e[31:0], st[31:0],
                         16'($urandom_range(0, 5)), 8'($urandom_range(0, 4)));
                run_sweep("rand");
            end
        end
        rnd_hold_en = 1'b0;
        valid_mode  = 0;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual still running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
